// File: rtl/io_bus_ctrl.sv
// IO bus controller: decodes CPU IO loads/stores onto four peripherals,
// stalls the pipeline until the device acks, and flags bus errors.
module io_bus_ctrl #(
   parameter int TIMEOUT = 15
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         io_read,
   input  logic         io_write,
   input  logic [7:0]   io_addr,
   input  logic [31:0]  io_wdata,
   output logic [31:0]  io_rdata,
   output logic         io_stall,
   output logic [3:0]   dev_req,
   output logic         dev_we,
   output logic [3:0]   dev_addr,
   output logic [31:0]  dev_wdata,
   input  logic [3:0]   dev_ack,
   input  logic [127:0] dev_rdata,
   output logic         io_err,
   input  logic         err_clr
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t          state, state_next;
   logic [1:0]      sel_q;
   logic [3:0]      addr_q;
   logic            we_q;
   logic [31:0]     wdata_q;
   logic [CW-1:0]   wait_cnt;
   logic            any_req, good_req, ack_hit, timed_out, err_set;

   // A conflicting read+write or an address outside the device window
   // skips REQ entirely and reports an error on the detect edge.
   always_comb begin
      any_req    = io_read | io_write;
      good_req   = (io_read ^ io_write) && (io_addr[7:6] == 2'b01);
      ack_hit    = dev_ack[sel_q];
      timed_out  = !ack_hit && (wait_cnt == CW'(TIMEOUT - 1));
      state_next = state;
      io_stall   = 1'b0;
      dev_req    = 4'b0000;
      dev_we     = 1'b0;
      dev_addr   = 4'h0;
      dev_wdata  = 32'h0;
      err_set    = 1'b0;
      case (state)
         IDLE: begin
            io_stall = any_req;
            if (good_req) begin
               state_next = REQ;
            end else if (any_req) begin
               state_next = DONE;
               err_set    = 1'b1;
            end
         end
         REQ: begin
            io_stall  = 1'b1;
            dev_req   = 4'b0001 << sel_q;
            dev_we    = we_q;
            dev_addr  = addr_q;
            dev_wdata = wdata_q;
            err_set   = timed_out;
            if (ack_hit || timed_out) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Access fields are captured only in IDLE so the CPU may change its
   // request lines freely while the device transaction is in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sel_q    <= 2'b00;
         addr_q   <= 4'h0;
         we_q     <= 1'b0;
         wdata_q  <= 32'h0;
         wait_cnt <= '0;
         io_rdata <= 32'h0;
         io_err   <= 1'b0;
      end else begin
         io_err <= err_set | (io_err & ~err_clr);
         if (state == IDLE && any_req) begin
            sel_q    <= io_addr[5:4];
            addr_q   <= io_addr[3:0];
            we_q     <= io_write;
            wdata_q  <= io_wdata;
            wait_cnt <= '0;
            if (!good_req && io_read) io_rdata <= 32'h0;
         end else if (state == REQ) begin
            if (ack_hit) begin
               if (!we_q) io_rdata <= dev_rdata[{sel_q, 5'b00000} +: 32];
            end else begin
               wait_cnt <= wait_cnt + CW'(1);
               if (timed_out && !we_q) io_rdata <= 32'hFFFF_FFFF;
            end
         end
      end
   end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed bench for io_bus_ctrl: a vector table of complete accesses plus
// hand-written reset-abort and back-to-back sequences.
module tb_io_bus_ctrl;

   logic         clock;
   logic         reset;
   logic         io_read;
   logic         io_write;
   logic [7:0]   io_addr;
   logic [31:0]  io_wdata;
   logic [31:0]  io_rdata;
   logic         io_stall;
   logic [3:0]   dev_req;
   logic         dev_we;
   logic [3:0]   dev_addr;
   logic [31:0]  dev_wdata;
   logic [3:0]   dev_ack;
   logic [127:0] dev_rdata;
   logic         io_err;
   logic         err_clr;

   int total  = 0;
   int passed = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      int          ack_delay;
      int          exp_stall;
      int          exp_req;
      logic [3:0]  exp_dev_req;
      logic        exp_we;
      logic [3:0]  exp_daddr;
      logic [31:0] exp_dwdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[9];

   io_bus_ctrl #(.TIMEOUT(15)) dut (
      .clock     (clock),
      .reset     (reset),
      .io_read   (io_read),
      .io_write  (io_write),
      .io_addr   (io_addr),
      .io_wdata  (io_wdata),
      .io_rdata  (io_rdata),
      .io_stall  (io_stall),
      .dev_req   (dev_req),
      .dev_we    (dev_we),
      .dev_addr  (dev_addr),
      .dev_wdata (dev_wdata),
      .dev_ack   (dev_ack),
      .dev_rdata (dev_rdata),
      .io_err    (io_err),
      .err_clr   (err_clr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Runs one whole access from IDLE to DONE, acting as the device, then
   // clears the error flag during DONE and checks it dropped.
   task automatic apply_stimulus(input vec_t v);
      int         stall_cnt = 0;
      int         req_cnt   = 0;
      logic       finished  = 1'b0;
      logic       held      = 1'b1;
      logic [3:0] onehot    = 4'b0001 << v.addr[5:4];
      logic [3:0] cap_req   = 4'h0;
      logic       cap_we    = 1'b0;
      logic [3:0] cap_addr  = 4'h0;
      logic [31:0] cap_wdata = 32'h0;
      @(negedge clock);
      io_read  = v.rd;
      io_write = v.wr;
      io_addr  = v.addr;
      io_wdata = v.wdata;
      dev_ack  = 4'b0000;
      for (int c = 0; c < 40; c++) begin
         if (c > 0) @(negedge clock);
         #1;
         if (!io_stall) begin
            finished = 1'b1;
            break;
         end
         stall_cnt++;
         if (dev_req != 4'b0000) begin
            if (req_cnt == 0) begin
               cap_req   = dev_req;
               cap_we    = dev_we;
               cap_addr  = dev_addr;
               cap_wdata = dev_wdata;
            end else if (dev_req != cap_req || dev_we != cap_we ||
                         dev_addr != cap_addr || dev_wdata != cap_wdata) begin
               held = 1'b0;
            end
            io_addr  = ~v.addr;
            io_wdata = ~v.wdata;
            dev_ack  = ((req_cnt == v.ack_delay) ? onehot : 4'b0000) | ~onehot;
            req_cnt++;
         end
      end
      check_output("done_reached", finished, 1);
      check_output("stall_cycles", stall_cnt, v.exp_stall);
      check_output("req_cycles", req_cnt, v.exp_req);
      check_output("dev_req", cap_req, v.exp_dev_req);
      check_output("dev_we", cap_we, v.exp_we);
      check_output("dev_addr", cap_addr, v.exp_daddr);
      check_output("dev_wdata", cap_wdata, v.exp_dwdata);
      check_output("dev_held", held, 1);
      check_output("done_dev_req", dev_req, 0);
      check_output("io_rdata", io_rdata, v.exp_rdata);
      check_output("io_err", io_err, v.exp_err);
      io_read  = 1'b0;
      io_write = 1'b0;
      dev_ack  = 4'b0000;
      err_clr  = 1'b1;
      @(negedge clock);
      #1;
      check_output("err_cleared", io_err, 0);
      err_clr = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      io_read   = 1'b0;
      io_write  = 1'b0;
      io_addr   = 8'h00;
      io_wdata  = 32'h0;
      dev_ack   = 4'b0000;
      err_clr   = 1'b0;
      dev_rdata = {32'h3333_CAFE, 32'h2222_2222, 32'h0000_00A5, 32'h1111_0000};

      //           rd    wr    addr   wdata          dly stl req dreq     we    daddr dwdata         rdata          err
      vecs[0] = '{1'b1, 1'b0, 8'h52, 32'hDEAD_BEEF,  0,  2,  1, 4'b0010, 1'b0, 4'h2, 32'hDEAD_BEEF, 32'h0000_00A5, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 8'h63, 32'h1234_5678,  3,  5,  4, 4'b0100, 1'b1, 4'h3, 32'h1234_5678, 32'h0000_00A5, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 8'h40, 32'h0000_0000, -1, 16, 15, 4'b0001, 1'b0, 4'h0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
      vecs[3] = '{1'b1, 1'b0, 8'hC0, 32'h0000_0000, -1,  1,  0, 4'b0000, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};
      vecs[4] = '{1'b1, 1'b0, 8'h7E, 32'hCAFE_F00D,  1,  3,  2, 4'b1000, 1'b0, 4'hE, 32'hCAFE_F00D, 32'h3333_CAFE, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 8'h00, 32'hAAAA_5555, -1,  1,  0, 4'b0000, 1'b0, 4'h0, 32'h0000_0000, 32'h3333_CAFE, 1'b1};
      vecs[6] = '{1'b1, 1'b1, 8'h52, 32'h0000_0000, -1,  1,  0, 4'b0000, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};
      vecs[7] = '{1'b1, 1'b0, 8'h5F, 32'h0000_0000, 14, 16, 15, 4'b0010, 1'b0, 4'hF, 32'h0000_0000, 32'h0000_00A5, 1'b0};
      vecs[8] = '{1'b0, 1'b1, 8'h4B, 32'h0BAD_F00D, -1, 16, 15, 4'b0001, 1'b1, 4'hB, 32'h0BAD_F00D, 32'h0000_00A5, 1'b1};

      repeat (2) @(negedge clock);
      #1;
      check_output("rst_rdata", io_rdata, 0);
      check_output("rst_err", io_err, 0);
      check_output("rst_dev_req", dev_req, 0);
      check_output("rst_dev_we", dev_we, 0);
      check_output("rst_dev_addr", dev_addr, 0);
      check_output("rst_dev_wdata", dev_wdata, 0);
      check_output("rst_stall", io_stall, 0);
      reset = 1'b0;

      for (int i = 0; i < 9; i++) apply_stimulus(vecs[i]);

      // Reset in the middle of a device wait aborts without an error.
      @(negedge clock);
      io_read = 1'b1;
      io_addr = 8'h63;
      repeat (3) @(negedge clock);
      #1;
      check_output("abort_pre_req", dev_req, 4'b0100);
      io_read = 1'b0;
      reset   = 1'b1;
      #1;
      check_output("abort_dev_req", dev_req, 0);
      check_output("abort_stall", io_stall, 0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check_output("abort_err", io_err, 0);
      check_output("abort_rdata", io_rdata, 0);
      apply_stimulus(vecs[0]);

      // Back-to-back reads: io_read stays high across DONE.
      @(negedge clock);
      io_read = 1'b1;
      io_addr = 8'h41;
      #1;
      check_output("b2b_idle1_stall", io_stall, 1);
      check_output("b2b_idle1_req", dev_req, 0);
      @(negedge clock);
      #1;
      check_output("b2b_req1", dev_req, 4'b0001);
      dev_ack = 4'b0001;
      @(negedge clock);
      #1;
      dev_ack = 4'b0000;
      check_output("b2b_done1_stall", io_stall, 0);
      check_output("b2b_rdata1", io_rdata, 32'h1111_0000);
      io_addr = 8'h7C;
      @(negedge clock);
      #1;
      check_output("b2b_idle2_stall", io_stall, 1);
      check_output("b2b_idle2_req", dev_req, 0);
      @(negedge clock);
      #1;
      check_output("b2b_req2", dev_req, 4'b1000);
      check_output("b2b_addr2", dev_addr, 4'hC);
      dev_ack = 4'b1000;
      @(negedge clock);
      #1;
      dev_ack = 4'b0000;
      io_read = 1'b0;
      check_output("b2b_done2_stall", io_stall, 0);
      check_output("b2b_rdata2", io_rdata, 32'h3333_CAFE);
      check_output("b2b_err", io_err, 0);
      @(negedge clock);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
